// File: rtl/spi_slave_tx_if.sv
// Bus bundle for the SPI responder transmitter: SPI pins plus the local
// load/ready handshake and the status strobes.
interface spi_slave_tx_if #(
    parameter int WIDTH = 12
);
    logic             sclk;
    logic             cs;
    logic             miso;
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             busy;
    logic             done;
    logic             underrun;
    logic             aborted;

    // Transmitter side
    modport slave (
        input  sclk, cs, din, load,
        output miso, ready, busy, done, underrun, aborted
    );

    // SPI master / local producer side
    modport master (
        output sclk, cs, din, load,
        input  miso, ready, busy, done, underrun, aborted
    );
endinterface

// File: rtl/spi_slave_tx.sv
// SPI responder-side transmitter. Runs on clk only; sclk and cs are
// synchronized, edge-detected into single-cycle strobes, and the word in
// the holding register is shifted out LSB first on miso.
module spi_slave_tx #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    spi_slave_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    // Synchronizer chains; vld tracks which stages hold real pin samples so
    // the cs reset value (high) meeting a low pin never looks like a fall.
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] vld_sync_reg;
    logic                   sclk_prev_reg;
    logic                   cs_prev_reg;
    logic                   vld_prev_reg;
    logic                   sclk_rise_reg;
    logic                   sclk_fall_reg;
    logic                   cs_rise_reg;
    logic                   cs_fall_reg;
    logic                   sclk_last;
    logic                   cs_last;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     hold_reg, hold_next;
    logic                 hold_valid_reg, hold_valid_next;
    logic [WIDTH-1:0]     shreg_reg, shreg_next;
    logic [CNT_W-1:0]     bitcnt_reg, bitcnt_next;
    logic                 miso_reg, miso_next;
    logic                 done_reg, done_next;
    logic                 underrun_reg, underrun_next;
    logic                 aborted_reg, aborted_next;

    assign sclk_last = sclk_sync_reg[SYNC_STAGES-1];
    assign cs_last   = cs_sync_reg[SYNC_STAGES-1];

    // Synchronize the pins and register edge strobes (strobe lands
    // SYNC_STAGES+1 cycles after the pin changes).
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '1;
            vld_sync_reg  <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
            vld_prev_reg  <= 1'b0;
            sclk_rise_reg <= 1'b0;
            sclk_fall_reg <= 1'b0;
            cs_rise_reg   <= 1'b0;
            cs_fall_reg   <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs};
            vld_sync_reg  <= {vld_sync_reg[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_reg <= sclk_last;
            cs_prev_reg   <= cs_last;
            vld_prev_reg  <= vld_sync_reg[SYNC_STAGES-1];
            sclk_rise_reg <= vld_prev_reg && !sclk_prev_reg && sclk_last;
            sclk_fall_reg <= vld_prev_reg && sclk_prev_reg && !sclk_last;
            cs_rise_reg   <= vld_prev_reg && !cs_prev_reg && cs_last;
            cs_fall_reg   <= vld_prev_reg && cs_prev_reg && !cs_last;
        end
    end

    // State, holding register and shifter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            shreg_reg      <= '0;
            bitcnt_reg     <= '0;
            miso_reg       <= 1'b0;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            shreg_reg      <= shreg_next;
            bitcnt_reg     <= bitcnt_next;
            miso_reg       <= miso_next;
            done_reg       <= done_next;
            underrun_reg   <= underrun_next;
            aborted_reg    <= aborted_next;
        end
    end

    // Next-state logic: handshake capture, frame start, shifting, abort.
    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        shreg_next      = shreg_reg;
        bitcnt_next     = bitcnt_reg;
        miso_next       = miso_reg;
        done_next       = 1'b0;
        underrun_next   = 1'b0;
        aborted_next    = 1'b0;

        // A load accepted while a frame starts goes to the next frame;
        // the starting frame sees the register as it was (empty).
        if (bus.load && !hold_valid_reg) begin
            hold_next       = bus.din;
            hold_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                miso_next = 1'b0;
                if (cs_fall_reg) begin
                    state_next  = SHIFT;
                    bitcnt_next = '0;
                    if (hold_valid_reg) begin
                        shreg_next      = hold_reg;
                        miso_next       = hold_reg[0];
                        hold_valid_next = 1'b0;
                    end else begin
                        shreg_next    = '0;
                        miso_next     = 1'b0;
                        underrun_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise_reg) begin
                    state_next   = IDLE;
                    miso_next    = 1'b0;
                    aborted_next = 1'b1;
                end else begin
                    if (sclk_rise_reg) begin
                        if (bitcnt_reg == CNT_W'(WIDTH - 1)) begin
                            state_next = FINISH;
                            miso_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            bitcnt_next = bitcnt_reg + 1'b1;
                        end
                    end
                    // Bit 0 was presented at frame start, so the fall
                    // before the first rise must not shift.
                    if (sclk_fall_reg && (bitcnt_reg != '0)) begin
                        shreg_next = shreg_reg >> 1;
                        miso_next  = shreg_reg[1];
                    end
                end
            end
            FINISH: begin
                miso_next = 1'b0;
                if (cs_rise_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                miso_next  = 1'b0;
            end
        endcase
    end

    assign bus.miso     = miso_reg;
    assign bus.ready    = !hold_valid_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.underrun = underrun_reg;
    assign bus.aborted  = aborted_reg;
endmodule

// File: tb/tb_spi_slave_tx.sv
// Testbench for spi_slave_tx: acts as SPI master and local producer,
// predicts each frame from a one-entry holding-buffer model.
module tb_spi_slave_tx;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_tx_if #(.WIDTH(W)) bus ();

    spi_slave_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse counters observed on the falling edge
    int done_cnt = 0;
    int under_cnt = 0;
    int abort_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (bus.done)     done_cnt++;
        if (bus.underrun) under_cnt++;
        if (bus.aborted)  abort_cnt++;
        if (bus.busy)     busy_cnt++;
    end

    // Reference model: the one-deep holding buffer
    bit             model_valid = 1'b0;
    logic [W-1:0]   model_word  = '0;

    typedef struct {
        bit           do_load;
        logic [W-1:0] din;
        logic [W-1:0] exp_word;
        bit           exp_under;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] w);
        bit exp_ready;
        exp_ready = !model_valid;
        chk("ready_before_load", {31'b0, bus.ready}, {31'b0, exp_ready});
        bus.din  = w;
        bus.load = 1'b1;
        wait_clk(1);
        bus.load = 1'b0;
        if (exp_ready) begin
            model_valid = 1'b1;
            model_word  = w;
        end
        chk("ready_after_load", {31'b0, bus.ready}, 32'd0);
        $display("load %03h accepted=%0d", w, exp_ready);
    endtask

    // One full frame: 12 sampled bits, optional extra sclk pulses in FINISH.
    task automatic check_frame(input string name, input logic [W-1:0] exp_word,
                               input bit exp_under, input int half, input int extra);
        logic [W-1:0] rx;
        int d0, u0, a0;
        d0 = done_cnt; u0 = under_cnt; a0 = abort_cnt;
        model_valid = 1'b0;
        rx = '0;
        bus.cs = 1'b0;
        wait_clk(8);
        chk({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
        chk({name, "_ready_mid"}, {31'b0, bus.ready}, 32'd1);
        for (int i = 0; i < W; i++) begin
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            wait_clk(half);
            bus.sclk = 1'b0;
            wait_clk(half);
        end
        for (int i = 0; i < extra; i++) begin
            bus.sclk = 1'b1;
            wait_clk(half);
            bus.sclk = 1'b0;
            wait_clk(half);
        end
        wait_clk(8);
        chk({name, "_miso_finish"}, {31'b0, bus.miso}, 32'd0);
        chk({name, "_done_cnt"}, done_cnt - d0, 32'd1);
        bus.cs = 1'b1;
        wait_clk(8);
        chk({name, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
        chk({name, "_word"}, {20'b0, rx}, {20'b0, exp_word});
        chk({name, "_underrun"}, under_cnt - u0, {31'b0, exp_under});
        chk({name, "_aborted"}, abort_cnt - a0, 32'd0);
        $display("frame %s: sent %03h expected %03h underrun=%0d", name, rx, exp_word, under_cnt - u0);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] w;
        int d0, u0, a0, b0;

        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.din  = '0;
        bus.load = 1'b0;

        // Reset values
        wait_clk(3);
        chk("rst_miso", {31'b0, bus.miso}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_underrun", {31'b0, bus.underrun}, 32'd0);
        chk("rst_aborted", {31'b0, bus.aborted}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Table-driven frames
        vecs[0] = '{do_load: 1'b1, din: 12'hA5C, exp_word: 12'hA5C, exp_under: 1'b0};
        vecs[1] = '{do_load: 1'b0, din: 12'h000, exp_word: 12'h000, exp_under: 1'b1};
        vecs[2] = '{do_load: 1'b1, din: 12'h800, exp_word: 12'h800, exp_under: 1'b0};
        vecs[3] = '{do_load: 1'b1, din: 12'h555, exp_word: 12'h555, exp_under: 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_load) do_load(vecs[i].din);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_under, 11, 0);
        end

        // Double buffering: load during frame, third load ignored
        do_load(12'h001);
        fork
            check_frame("dbuf1", 12'h001, 1'b0, 11, 0);
            begin
                wait_clk(40);
                do_load(12'hFFF);
            end
        join
        do_load(12'h123);
        check_frame("dbuf2", 12'hFFF, 1'b0, 11, 0);

        // Abort after 5 rises
        do_load(12'h7E7);
        model_valid = 1'b0;
        d0 = done_cnt; a0 = abort_cnt;
        rx = '0;
        bus.cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 5; i++) begin
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            wait_clk(8);
            bus.sclk = 1'b0;
            wait_clk(8);
        end
        bus.cs = 1'b1;
        wait_clk(8);
        chk("abort_pulse", abort_cnt - a0, 32'd1);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_miso", {31'b0, bus.miso}, 32'd0);
        chk("abort_partial", {27'b0, rx[4:0]}, 32'h07);
        $display("abort: partial bits %02h", rx[4:0]);
        do_load(12'h3C3);
        check_frame("after_abort", 12'h3C3, 1'b0, 9, 0);

        // Extra sclk pulses while idle
        d0 = done_cnt; u0 = under_cnt; b0 = busy_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.sclk = 1'b1; wait_clk(6);
            bus.sclk = 1'b0; wait_clk(6);
        end
        chk("idle_sclk_busy", busy_cnt - b0, 32'd0);
        chk("idle_sclk_done", done_cnt - d0, 32'd0);
        chk("idle_sclk_miso", {31'b0, bus.miso}, 32'd0);
        $display("idle sclk pulses: busy cycles %0d", busy_cnt - b0);

        // Extra sclk pulses in FINISH, then a normal frame
        do_load(12'h9B6);
        check_frame("finish_extra", 12'h9B6, 1'b0, 7, 3);
        do_load(12'h4D2);
        check_frame("post_extra", 12'h4D2, 1'b0, 7, 0);

        // Reset mid-frame with cs held low
        do_load(12'h5A5);
        d0 = done_cnt; a0 = abort_cnt;
        bus.cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 7; i++) begin
            bus.sclk = 1'b1; wait_clk(7);
            bus.sclk = 1'b0; wait_clk(7);
        end
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        model_valid = 1'b0;
        wait_clk(1);
        chk("mid_rst_miso", {31'b0, bus.miso}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        u0 = under_cnt; b0 = busy_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.sclk = 1'b1; wait_clk(7);
            bus.sclk = 1'b0; wait_clk(7);
        end
        wait_clk(10);
        chk("mid_rst_no_busy", busy_cnt - b0, 32'd0);
        chk("mid_rst_no_underrun", under_cnt - u0, 32'd0);
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        chk("mid_rst_no_abort", abort_cnt - a0, 32'd0);
        $display("reset mid-frame: busy cycles after reset %0d", busy_cnt - b0);
        bus.cs = 1'b1;
        wait_clk(10);
        check_frame("after_rst", 12'h000, 1'b1, 8, 0);

        // Randomized frames against the holding-buffer model
        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] exp_w;
            bit           exp_u;
            if ($urandom_range(0, 9) < 7) begin
                w = W'($urandom);
                do_load(w);
                if ($urandom_range(0, 1) == 1) begin
                    w = W'($urandom);
                    do_load(w);
                end
            end
            exp_w = model_valid ? model_word : '0;
            exp_u = !model_valid;
            check_frame($sformatf("rand%0d", n), exp_w, exp_u, int'($urandom_range(6, 12)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
